// File: rtl/i2c_arb.sv
// Two-client arbiter in front of a byte-oriented I2C master core: grants one client
// per transaction, paces bytes against the core busy flag and closes every transaction with STOP.
module i2c_arb #(
  parameter int unsigned STALL_MAX = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] c0_data,
  input  logic       c0_last,
  input  logic       c0_valid,
  output logic       c0_ready,
  input  logic [7:0] c1_data,
  input  logic       c1_last,
  input  logic       c1_valid,
  output logic       c1_ready,
  output logic [8:0] data,
  output logic       wr,
  input  logic       busy,
  output logic [1:0] gnt,
  output logic       abort
);

  localparam int unsigned CW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX - 1);
  localparam logic [8:0] STOP_WORD = 9'h100;

  typedef enum logic [3:0] {
    FLUSH, FGAP, FWAIT, IDLE, SEND, GAP, WAIT, STOP, SGAP, SWAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] stall_cnt;
  logic          last_q;
  logic          rr;
  logic          owner;

  logic          pick;
  logic          sel;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;

  // In IDLE the candidate comes from the round-robin choice, afterwards from the owner.
  assign pick      = (c0_valid && c1_valid) ? rr : c1_valid;
  assign sel       = (state == IDLE) ? pick : owner;
  assign sel_valid = sel ? c1_valid : c0_valid;
  assign sel_last  = sel ? c1_last  : c0_last;
  assign sel_data  = sel ? c1_data  : c0_data;

  // NOTE: all state and outputs use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      gnt       <= 2'b00;
      wr        <= 1'b0;
      data      <= 9'h000;
      abort     <= 1'b0;
      c0_ready  <= 1'b0;
      c1_ready  <= 1'b0;
      stall_cnt <= '0;
      last_q    <= 1'b0;
      rr        <= 1'b0;
      owner     <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each one lasts exactly one clock.
      wr       <= 1'b0;
      data     <= 9'h000;
      abort    <= 1'b0;
      c0_ready <= 1'b0;
      c1_ready <= 1'b0;

      case (state)
        FLUSH: begin
          if (!busy) begin
            wr    <= 1'b1;
            data  <= STOP_WORD;
            state <= FGAP;
          end
        end
        FGAP:  state <= FWAIT;
        FWAIT: if (!busy) state <= IDLE;
        IDLE: begin
          if (c0_valid || c1_valid) begin
            owner    <= pick;
            gnt      <= pick ? 2'b10 : 2'b01;
            wr       <= 1'b1;
            data     <= {1'b0, sel_data};
            c0_ready <= ~pick;
            c1_ready <= pick;
            last_q   <= sel_last;
            state    <= SEND;
          end
        end
        SEND: state <= GAP;
        GAP: begin
          stall_cnt <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (!busy) begin
            if (last_q) begin
              wr    <= 1'b1;
              data  <= STOP_WORD;
              state <= STOP;
            end else if (sel_valid) begin
              wr       <= 1'b1;
              data     <= {1'b0, sel_data};
              c0_ready <= ~owner;
              c1_ready <= owner;
              last_q   <= sel_last;
              state    <= SEND;
            end else if (stall_cnt == STALL_LIM) begin
              // Owner went quiet too long: release the bus rather than hold it forever.
              abort <= 1'b1;
              wr    <= 1'b1;
              data  <= STOP_WORD;
              state <= STOP;
            end else begin
              stall_cnt <= stall_cnt + CW'(1);
            end
          end
        end
        STOP: state <= SGAP;
        SGAP: state <= SWAIT;
        SWAIT: begin
          if (!busy) begin
            gnt   <= 2'b00;
            rr    <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arb.sv
// Self-checking bench for i2c_arb: two client drivers, a busy-flag core model and a
// scoreboard of expected core words checked on every wr strobe.
module tb_i2c_arb;

  localparam int STALL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] c0_data, c1_data;
  logic       c0_last, c1_last, c0_valid, c1_valid, c0_ready, c1_ready;
  logic [8:0] data;
  logic       wr, busy, abort;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  i2c_arb #(.STALL_MAX(STALL)) dut (
    .clk(clk), .rst(rst),
    .c0_data(c0_data), .c0_last(c0_last), .c0_valid(c0_valid), .c0_ready(c0_ready),
    .c1_data(c1_data), .c1_last(c1_last), .c1_valid(c1_valid), .c1_ready(c1_ready),
    .data(data), .wr(wr), .busy(busy), .gnt(gnt), .abort(abort)
  );

  typedef struct {
    int         tid;
    logic       cl;
    logic [7:0] d;
    logic       last;
    logic       stop;
  } row_t;
  typedef struct { logic [8:0] word; logic [1:0] gnt; } exp_t;
  typedef struct { logic [7:0] d; logic last; } cbyte_t;

  localparam int NV = 22;
  row_t   vec[NV];
  exp_t   exp_q[$];
  cbyte_t q0[$], q1[$];

  int checks = 0, failures = 0;
  int cyc = 0, last_wr_cyc = -1000, last_gap = 0;
  int wr_cnt = 0, abort_cnt = 0, acc0 = 0, acc1 = 0;
  int busy_len = 3, busy_cnt = 0;
  logic abort_prev = 1'b0;
  logic [1:0] gnt_prev = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // I2C core model: busy for busy_len cycles starting the cycle after a write.
  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (wr) busy_cnt <= busy_len;
  end
  assign busy = (busy_cnt != 0);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Push one test's rows into the client queues and the expected-word scoreboard.
  task automatic apply_table(input int tid);
    exp_t   e;
    cbyte_t b;
    for (int i = 0; i < NV; i++) begin
      if (vec[i].tid == tid) begin
        e.gnt  = vec[i].cl ? 2'b10 : 2'b01;
        e.word = vec[i].stop ? 9'h100 : {1'b0, vec[i].d};
        exp_q.push_back(e);
        if (!vec[i].stop) begin
          b.d = vec[i].d;
          b.last = vec[i].last;
          if (vec[i].cl) q1.push_back(b);
          else q0.push_back(b);
        end
      end
    end
  endtask

  task automatic push_flush();
    exp_t e;
    e.word = 9'h100;
    e.gnt  = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || gnt != 2'b00 || c0_valid || c1_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, 2'b00);
    check("rst_wr", wr, 1'b0);
    check("rst_data", data, 9'h000);
    check("rst_abort", abort, 1'b0);
    check("rst_ready", {c1_ready, c0_ready}, 2'b00);
  endtask

  // Client drivers: hold a byte until the accept strobe, then present the next one.
  initial begin
    c0_valid = 1'b0; c0_data = 8'h00; c0_last = 1'b0;
    forever begin
      @(negedge clk);
      if (c0_valid && c0_ready) begin
        q0.delete(0);
        acc0++;
      end else if (q0.size() != 0) begin
        c0_valid = 1'b1; c0_data = q0[0].d; c0_last = q0[0].last;
      end else begin
        c0_valid = 1'b0; c0_data = 8'h00; c0_last = 1'b0;
      end
    end
  end

  initial begin
    c1_valid = 1'b0; c1_data = 8'h00; c1_last = 1'b0;
    forever begin
      @(negedge clk);
      if (c1_valid && c1_ready) begin
        q1.delete(0);
        acc1++;
      end else if (q1.size() != 0) begin
        c1_valid = 1'b1; c1_data = q1[0].d; c1_last = q1[0].last;
      end else begin
        c1_valid = 1'b0; c1_data = 8'h00; c1_last = 1'b0;
      end
    end
  end

  // Bus monitor: scoreboard pop on each write plus protocol rules.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (wr) begin
      wr_cnt++;
      check("wr_while_busy", busy, 1'b0);
      check("wr_spacing", (cyc - last_wr_cyc) >= 3, 1'b1);
      last_gap = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      check("wr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_word", data, e.word);
        check("wr_gnt", gnt, e.gnt);
      end
    end
    if (c0_ready || c1_ready) check("ready_owner", {c1_ready, c0_ready, wr}, {gnt, 1'b1});
    if (abort) begin
      abort_cnt++;
      check("abort_single", abort_prev, 1'b0);
    end
    if (gnt != gnt_prev && gnt != 2'b00 && gnt_prev != 2'b00) check("gnt_stable", gnt, gnt_prev);
    abort_prev = abort;
    gnt_prev = gnt;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a1, ab, n;
    rst = 1'b1;
    vec = '{
      '{30, 1'b0, 8'h78, 1'b0, 1'b0}, '{30, 1'b0, 8'h00, 1'b0, 1'b0},
      '{30, 1'b0, 8'hAF, 1'b1, 1'b0}, '{30, 1'b0, 8'h00, 1'b0, 1'b1},
      '{31, 1'b0, 8'h11, 1'b0, 1'b0}, '{31, 1'b0, 8'h22, 1'b1, 1'b0},
      '{31, 1'b0, 8'h00, 1'b0, 1'b1}, '{31, 1'b1, 8'h33, 1'b1, 1'b0},
      '{31, 1'b1, 8'h00, 1'b0, 1'b1}, '{31, 1'b0, 8'h44, 1'b1, 1'b0},
      '{31, 1'b0, 8'h00, 1'b0, 1'b1}, '{31, 1'b1, 8'h55, 1'b1, 1'b0},
      '{31, 1'b1, 8'h00, 1'b0, 1'b1},
      '{32, 1'b1, 8'h3C, 1'b0, 1'b0}, '{32, 1'b1, 8'h00, 1'b0, 1'b1},
      '{33, 1'b0, 8'h5A, 1'b0, 1'b0},
      '{331, 1'b0, 8'h66, 1'b1, 1'b0}, '{331, 1'b0, 8'h00, 1'b0, 1'b1},
      '{34, 1'b1, 8'hA1, 1'b0, 1'b0}, '{34, 1'b1, 8'hA2, 1'b0, 1'b0},
      '{34, 1'b1, 8'hA3, 1'b1, 1'b0}, '{34, 1'b1, 8'h00, 1'b0, 1'b1}
    };

    // Reset flush: exactly one STOP word, then idle.
    push_flush();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    wait_drain("drain_flush", 200);
    repeat (20) @(negedge clk);
    check("flush_wr_count", wr_cnt, 1);
    check("flush_gnt_idle", gnt, 2'b00);

    // Single client 0 transaction.
    a0 = acc0;
    apply_table(30);
    wait_drain("drain_c0", 500);
    check("c0_ready_pulses", acc0 - a0, 3);

    // Round-robin after a fresh reset with both clients requesting.
    @(negedge clk);
    rst = 1'b1;
    push_flush();
    a0 = acc0;
    a1 = acc1;
    apply_table(31);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_drain("drain_rr", 1500);
    check("rr_c0_bytes", acc0 - a0, 3);
    check("rr_c1_bytes", acc1 - a1, 2);

    // Stall timeout on client 1.
    ab = abort_cnt;
    apply_table(32);
    wait_drain("drain_stall", 500);
    check("stall_abort_count", abort_cnt - ab, 1);
    check("stall_stop_delay", last_gap, busy_len + STALL + 1);
    check("stall_gnt_idle", gnt, 2'b00);

    // Reset while the owner holds the bus in WAIT with the core idle.
    ab = abort_cnt;
    a0 = acc0;
    apply_table(33);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_first_byte", n < 200, 1'b1);
    repeat (busy_len + 3) @(negedge clk);
    check("rst_mid_held", gnt, 2'b01);
    rst = 1'b1;
    push_flush();
    apply_table(331);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    wait_drain("drain_rst_mid", 500);
    check("rst_mid_no_abort", abort_cnt - ab, 0);
    check("rst_mid_bytes", acc0 - a0, 2);

    // Slow core: 50 busy cycles per word.
    busy_len = 50;
    a1 = acc1;
    apply_table(34);
    wait_drain("drain_slow", 2000);
    check("slow_c1_bytes", acc1 - a1, 3);
    check("slow_stop_gap", last_gap >= 51, 1'b1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter STALL_MAX, default 4095, is the maximum number of cycles the owner may leave the bus waiting for its next byte before the transaction is aborted.
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  is the reset; it is synchronous and active-high.
REQ-004 Ports c0_data / c1_data  input  8  carry the next byte from client 0 / client 1.
REQ-005 Ports c0_last / c1_last  input  1  mark the byte as the final byte of the transaction.
REQ-006 Ports c0_valid / c1_valid  input  1  indicate that the byte is presented.
REQ-007 Ports c0_ready / c1_ready  output  1  are one-cycle accept strobes; a byte is transferred when valid and ready are both high.
REQ-008 Port data  output  9  is the word to the I2C core: bit8=0 sends data[7:0] (the core generates START if it is idle); bit8=1 issues STOP.
REQ-009 Port wr  output  1  is a one-cycle write strobe to the I2C core.
REQ-010 Port busy  input  1  is the I2C core busy flag; it rises the cycle after an accepted wr and is low while the core waits between bytes.
REQ-011 Port gnt  output  2  is the one-hot current owner, and is 0 when no client owns the bus.
REQ-012 Port abort  output  1  is a one-cycle pulse when a transaction is terminated by stall timeout.

Function
REQ-013 States: FLUSH, FGAP, FWAIT, IDLE, SEND, GAP, WAIT, STOP, SGAP, SWAIT.
REQ-014 IDLE: if any cN_valid is high, grant one client and go to SEND.
- Only one valid: grant that client.
- Both valid: grant the client not served last (round-robin pointer); after reset the pointer favours client 0.
REQ-015 SEND (1 cycle):
- wr=1, data={1'b0, cN_data}, cN_ready=1 for the owner only.
- Latch cN_last, then go to GAP.
REQ-016 GAP (1 cycle): ignore busy, then go to WAIT.
REQ-017 WAIT: hold while busy=1. When busy=0:
- If the latched last=1, go to STOP.
- Else if the owner's valid=1, go to SEND.
- Else stay in WAIT and increment the stall counter.
REQ-018 Stall counter: cleared on entry to WAIT.
- When it reaches STALL_MAX with the owner still not valid: pulse abort and go to STOP.
- No byte is accepted in the cycle the timeout fires.
REQ-019 STOP (1 cycle): wr=1, data=9'h100, then go to SGAP (1 cycle), then SWAIT.
REQ-020 SWAIT: when busy=0, go to IDLE, clear gnt, and point round-robin at the other client.
REQ-021 The non-owner's ready stays 0 throughout a transaction; its valid is ignored until IDLE.
REQ-022 wr is never asserted in two consecutive cycles, and never while busy=1.
REQ-023 The gnt bit is set from the SEND entry until SWAIT exits, and is held constant within the transaction.
REQ-024 When the owner's valid drops between bytes, the bus stays held with no STOP until the timeout fires.
REQ-025 In the outputs data and wr, 0 means wr=0 and data=9'h000 in every state except SEND and STOP.

Reset
REQ-026 While rst=1, the block drives the following on the next edge:
- State=FLUSH, gnt=0, wr=0, data=0, abort=0, ready=0.
- Stall counter=0, latched last=0, round-robin pointer=client 0.
REQ-027 FLUSH waits for busy=0, then issues one STOP word (wr=1, data=9'h100), then FGAP (1 cycle), then FWAIT (until busy=0), then IDLE. This closes any transaction left open in the unreset I2C core; an idle core ignores the STOP word.
REQ-028 Asserting rst mid-transaction abandons it immediately and the FLUSH sequence terminates it on the bus; no abort pulse is generated.

Verification
REQ-029 Reset with a busy model idle: exactly one wr with data=9'h100 is seen, then IDLE with gnt=0 and no further wr.
REQ-030 Client 0 sends 0x78, 0x00, 0xAF (last on 0xAF):
- wr words are 0x078, 0x000, 0x0AF, 0x100 in order.
- c0_ready pulses 3 times and gnt=01 throughout.
REQ-031 Both clients valid in IDLE after reset:
- Client 0 is served first.
- Client 1 transaction follows immediately after SWAIT.
- A third simultaneous request goes to client 0.
REQ-032 With STALL_MAX=8, client 1 sends 0x3C non-last, then drops valid:
- After 8 cycles in WAIT with busy=0, abort pulses once and wr issues 0x100.
- gnt returns to 0.
REQ-033 rst asserted while in WAIT with busy=0: the next wr is 0x100, no further bytes are accepted, and the block then returns to IDLE.
REQ-034 Busy model holding busy high for 50 cycles per word: no wr while busy=1, and at least 2 cycles between successive wr strobes.
